// File: rtl/ysyx_arb_pkg.sv
// Shared types and constants for the N-channel bus arbiter.
// The optional burst mode is enabled by defining YSYX_ARB_BURST_EN.
package ysyx_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RADDR = 3'd1,
    ST_RDATA = 3'd2,
    ST_WREQ  = 3'd3,
    ST_WRESP = 3'd4
  } arb_state_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic int rr_ptr_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ysyx_rr_arbiter.sv
// Combinational rotate-priority select: lowest valid index >= rr_ptr,
// otherwise wrap to the lowest valid index overall.
module ysyx_rr_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter  int N_CH  = 2,
  localparam int PTR_W = rr_ptr_width(N_CH)
) (
  input  logic [N_CH-1:0]  valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             grant_valid
);

  logic [PTR_W-1:0] hi_idx;
  logic [PTR_W-1:0] lo_idx;
  logic             hi_found;

  // Scan downwards so the last hit in each class is the lowest index.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (valid[i]) begin
        lo_idx = PTR_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_idx   = PTR_W'(i);
          hi_found = 1'b1;
        end
      end
    end
  end

  assign grant       = hi_found ? hi_idx : lo_idx;
  assign grant_valid = |valid;

endmodule

// File: rtl/ysyx_bus_arbiter.sv
// N-channel round-robin memory arbiter bridging to a single AXI4 master port.
// Define YSYX_ARB_BURST_EN to add ch_req_len and INCR burst support.
module ysyx_bus_arbiter
  import ysyx_arb_pkg::*;
#(
  parameter  int N_CH   = 2,
  parameter  int ADDR_W = 32,
  parameter  int DATA_W = 64,
  parameter  int ID_W   = 4,
  localparam int PTR_W  = rr_ptr_width(N_CH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_req_valid,
  input  logic [N_CH-1:0]          ch_req_write,
  input  logic [N_CH*ADDR_W-1:0]   ch_req_addr,
  input  logic [N_CH*3-1:0]        ch_req_size,
  input  logic [N_CH*DATA_W-1:0]   ch_req_wdata,
  input  logic [N_CH*STRB_W-1:0]   ch_req_wstrb,
`ifdef YSYX_ARB_BURST_EN
  input  logic [N_CH*8-1:0]        ch_req_len,
`endif
  output logic [N_CH-1:0]          ch_req_ready,
  output logic [N_CH-1:0]          ch_resp_valid,
  output logic [DATA_W-1:0]        ch_resp_data,
  output logic                     ch_resp_last,
  output logic                     ch_resp_err,
  output logic                     io_master_arvalid,
  input  logic                     io_master_arready,
  output logic [ADDR_W-1:0]        io_master_araddr,
  output logic [ID_W-1:0]          io_master_arid,
  output logic [7:0]               io_master_arlen,
  output logic [2:0]               io_master_arsize,
  output logic [1:0]               io_master_arburst,
  input  logic                     io_master_rvalid,
  output logic                     io_master_rready,
  input  logic [DATA_W-1:0]        io_master_rdata,
  input  logic [1:0]               io_master_rresp,
  input  logic                     io_master_rlast,
  input  logic [ID_W-1:0]          io_master_rid,
  output logic                     io_master_awvalid,
  input  logic                     io_master_awready,
  output logic [ADDR_W-1:0]        io_master_awaddr,
  output logic [ID_W-1:0]          io_master_awid,
  output logic [7:0]               io_master_awlen,
  output logic [2:0]               io_master_awsize,
  output logic [1:0]               io_master_awburst,
  output logic                     io_master_wvalid,
  input  logic                     io_master_wready,
  output logic [DATA_W-1:0]        io_master_wdata,
  output logic [STRB_W-1:0]        io_master_wstrb,
  output logic                     io_master_wlast,
  input  logic                     io_master_bvalid,
  output logic                     io_master_bready,
  input  logic [1:0]               io_master_bresp,
  input  logic [ID_W-1:0]          io_master_bid,
  output arb_state_e               dbg_state,
  output logic [PTR_W-1:0]         dbg_rr_ptr
);

  // Request handshake: a request is captured in the cycle where
  // ch_req_valid[i] and ch_req_ready[i] are both high; ready is a pulse.
  arb_state_e        state;
  logic [PTR_W-1:0]  rr_ptr, grant_q, arb_grant, sel_idx, next_ptr;
  logic              arb_valid, grant_fire, beat_fire;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [2:0]        size_q, sel_size;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  logic [STRB_W-1:0] wstrb_q, sel_wstrb;
  logic              sel_write;
  logic [N_CH-1:0]   grant_oh;
  logic [ID_W-1:0]   grant_id;
  logic              aw_done, w_done, r_err, b_err;
`ifdef YSYX_ARB_BURST_EN
  logic [7:0]        len_q, beat_q, sel_len;
`endif

  ysyx_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .valid       (ch_req_valid),
    .rr_ptr      (rr_ptr),
    .grant       (arb_grant),
    .grant_valid (arb_valid)
  );

  // Hold off arbitration during the final response pulse so grants never overlap it.
  assign grant_fire = reset && (state == ST_IDLE) && arb_valid && !(|ch_resp_valid);
  assign sel_idx    = (state == ST_IDLE) ? arb_grant : grant_q;
  assign next_ptr   = (grant_q == PTR_W'(N_CH - 1)) ? '0 : grant_q + PTR_W'(1);
  assign grant_id   = ID_W'(grant_q);
  assign aw_done    = !io_master_awvalid || io_master_awready;
  assign w_done     = !io_master_wvalid || (io_master_wready && io_master_wlast);
  assign b_err      = (io_master_bresp != RESP_OKAY) || (io_master_bid != grant_id);

`ifdef YSYX_ARB_BURST_EN
  assign beat_fire       = reset && (state == ST_WREQ) && io_master_wvalid &&
                           io_master_wready && !io_master_wlast;
  assign io_master_arlen = len_q;
  assign io_master_awlen = len_q;
  assign io_master_wlast = io_master_wvalid && (beat_q == len_q);
`else
  assign beat_fire       = 1'b0;
  assign io_master_arlen = 8'd0;
  assign io_master_awlen = 8'd0;
  assign io_master_wlast = io_master_wvalid;
`endif

  always_comb begin
    r_err = (io_master_rresp != RESP_OKAY) || (io_master_rid != grant_id);
`ifdef YSYX_ARB_BURST_EN
    if (io_master_rlast && (beat_q != len_q)) r_err = 1'b1;
`endif
  end

  always_comb begin
    sel_addr     = '0;
    sel_size     = '0;
    sel_wdata    = '0;
    sel_wstrb    = '0;
    sel_write    = 1'b0;
    grant_oh     = '0;
    ch_req_ready = '0;
`ifdef YSYX_ARB_BURST_EN
    sel_len      = '0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_addr        = ch_req_addr[i*ADDR_W +: ADDR_W];
        sel_size        = ch_req_size[i*3 +: 3];
        sel_wdata       = ch_req_wdata[i*DATA_W +: DATA_W];
        sel_wstrb       = ch_req_wstrb[i*STRB_W +: STRB_W];
        sel_write       = ch_req_write[i];
        ch_req_ready[i] = grant_fire || beat_fire;
`ifdef YSYX_ARB_BURST_EN
        sel_len         = ch_req_len[i*8 +: 8];
`endif
      end
      grant_oh[i] = (grant_q == PTR_W'(i));
    end
  end

  assign io_master_araddr  = addr_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_arsize  = size_q;
  assign io_master_awsize  = size_q;
  assign io_master_arid    = grant_id;
  assign io_master_awid    = grant_id;
  assign io_master_arburst = io_master_arvalid ? BURST_INCR : 2'b00;
  assign io_master_awburst = io_master_awvalid ? BURST_INCR : 2'b00;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign dbg_state         = state;
  assign dbg_rr_ptr        = rr_ptr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= ST_IDLE;
      rr_ptr            <= '0;
      grant_q           <= '0;
      addr_q            <= '0;
      size_q            <= '0;
      wdata_q           <= '0;
      wstrb_q           <= '0;
      io_master_arvalid <= 1'b0;
      io_master_rready  <= 1'b0;
      io_master_awvalid <= 1'b0;
      io_master_wvalid  <= 1'b0;
      io_master_bready  <= 1'b0;
      ch_resp_valid     <= '0;
      ch_resp_data      <= '0;
      ch_resp_last      <= 1'b0;
      ch_resp_err       <= 1'b0;
`ifdef YSYX_ARB_BURST_EN
      len_q             <= '0;
      beat_q            <= '0;
`endif
    end else begin
      ch_resp_valid <= '0;
      ch_resp_last  <= 1'b0;
      ch_resp_err   <= 1'b0;
      case (state)
        ST_IDLE: if (grant_fire) begin
          grant_q <= arb_grant;
          addr_q  <= sel_addr;
          size_q  <= sel_size;
          wdata_q <= sel_wdata;
          wstrb_q <= sel_wstrb;
`ifdef YSYX_ARB_BURST_EN
          len_q   <= sel_len;
          beat_q  <= '0;
`endif
          if (sel_write) begin
            state             <= ST_WREQ;
            io_master_awvalid <= 1'b1;
            io_master_wvalid  <= 1'b1;
          end else begin
            state             <= ST_RADDR;
            io_master_arvalid <= 1'b1;
          end
        end
        ST_RADDR: if (io_master_arready) begin
          io_master_arvalid <= 1'b0;
          io_master_rready  <= 1'b1;
          state             <= ST_RDATA;
        end
        ST_RDATA: if (io_master_rvalid) begin
          ch_resp_valid <= grant_oh;
          ch_resp_data  <= io_master_rdata;
          ch_resp_err   <= r_err;
          ch_resp_last  <= io_master_rlast;
`ifdef YSYX_ARB_BURST_EN
          beat_q        <= beat_q + 8'd1;
`endif
          if (io_master_rlast) begin
            io_master_rready <= 1'b0;
            rr_ptr           <= next_ptr;
            state            <= ST_IDLE;
          end
        end
        ST_WREQ: begin
          if (io_master_awready) io_master_awvalid <= 1'b0;
          if (io_master_wvalid && io_master_wready) begin
            if (io_master_wlast) io_master_wvalid <= 1'b0;
`ifdef YSYX_ARB_BURST_EN
            // Next beat comes from the requester, which was just pulsed ready.
            else begin
              beat_q  <= beat_q + 8'd1;
              wdata_q <= sel_wdata;
              wstrb_q <= sel_wstrb;
            end
`endif
          end
          if (aw_done && w_done) begin
            io_master_bready <= 1'b1;
            state            <= ST_WRESP;
          end
        end
        ST_WRESP: if (io_master_bvalid) begin
          ch_resp_valid    <= grant_oh;
          ch_resp_last     <= 1'b1;
          ch_resp_err      <= b_err;
          io_master_bready <= 1'b0;
          rr_ptr           <= next_ptr;
          state            <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_bus_arbiter.sv
// Directed bench for ysyx_bus_arbiter with three channels: reset, single read,
// round-robin contention, split write handshake, ID mismatch, reset mid-read.
module tb_ysyx_bus_arbiter;
  import ysyx_arb_pkg::*;

  localparam int N_CH = 3;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam int IW   = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [N_CH-1:0]  ch_req_valid, ch_req_write, ch_req_ready, ch_resp_valid;
  logic [N_CH*AW-1:0] ch_req_addr;
  logic [N_CH*3-1:0]  ch_req_size;
  logic [N_CH*DW-1:0] ch_req_wdata;
  logic [N_CH*8-1:0]  ch_req_wstrb;
`ifdef YSYX_ARB_BURST_EN
  logic [N_CH*8-1:0]  ch_req_len = '0;
`endif
  logic [DW-1:0]    ch_resp_data;
  logic             ch_resp_last, ch_resp_err;
  logic             io_master_arvalid, io_master_arready;
  logic [AW-1:0]    io_master_araddr, io_master_awaddr;
  logic [IW-1:0]    io_master_arid, io_master_rid, io_master_awid, io_master_bid;
  logic [7:0]       io_master_arlen, io_master_awlen, io_master_wstrb;
  logic [2:0]       io_master_arsize, io_master_awsize;
  logic [1:0]       io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp;
  logic             io_master_rvalid, io_master_rready, io_master_rlast;
  logic [DW-1:0]    io_master_rdata, io_master_wdata;
  logic             io_master_awvalid, io_master_awready;
  logic             io_master_wvalid, io_master_wready, io_master_wlast;
  logic             io_master_bvalid, io_master_bready;
  arb_state_e       dbg_state;
  logic [1:0]       dbg_rr_ptr;

  int n_vec;
  int n_err;

  ysyx_bus_arbiter #(.N_CH(N_CH), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clock(clock), .reset(reset),
    .ch_req_valid(ch_req_valid), .ch_req_write(ch_req_write),
    .ch_req_addr(ch_req_addr), .ch_req_size(ch_req_size),
    .ch_req_wdata(ch_req_wdata), .ch_req_wstrb(ch_req_wstrb),
`ifdef YSYX_ARB_BURST_EN
    .ch_req_len(ch_req_len),
`endif
    .ch_req_ready(ch_req_ready), .ch_resp_valid(ch_resp_valid),
    .ch_resp_data(ch_resp_data), .ch_resp_last(ch_resp_last), .ch_resp_err(ch_resp_err),
    .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
    .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
    .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
    .io_master_arburst(io_master_arburst),
    .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
    .io_master_rdata(io_master_rdata), .io_master_rresp(io_master_rresp),
    .io_master_rlast(io_master_rlast), .io_master_rid(io_master_rid),
    .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
    .io_master_awaddr(io_master_awaddr), .io_master_awid(io_master_awid),
    .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
    .io_master_awburst(io_master_awburst),
    .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast),
    .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
    .io_master_bresp(io_master_bresp), .io_master_bid(io_master_bid),
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
  endtask

  // Entered at the start of the grant cycle with the request already driven;
  // plays a zero-wait slave and returns at the negedge of the response cycle.
  task automatic read_txn(input int ch, input logic [31:0] addr, input logic [63:0] data,
                          input logic [3:0] r_id, input logic exp_err, input logic [1:0] exp_ptr);
    logic [2:0] oh;
    oh = 3'(1 << ch);
    @(negedge clock);
    check("grant_ready", 64'(ch_req_ready), 64'(oh));
    cyc();
    @(negedge clock);
    check("arvalid", 64'(io_master_arvalid), 64'd1);
    check("araddr", 64'(io_master_araddr), 64'(addr));
    check("arid", 64'(io_master_arid), 64'(ch));
    check("ar_len_size_burst", 64'({io_master_arlen, io_master_arsize, io_master_arburst}),
          64'({8'd0, 3'd3, 2'b01}));
    io_master_arready = 1'b1;
    cyc();
    io_master_arready = 1'b0;
    io_master_rvalid  = 1'b1;
    io_master_rdata   = data;
    io_master_rresp   = 2'b00;
    io_master_rid     = r_id;
    io_master_rlast   = 1'b1;
    @(negedge clock);
    check("rready", 64'(io_master_rready), 64'd1);
    check("arvalid_dropped", 64'(io_master_arvalid), 64'd0);
    cyc();
    io_master_rvalid = 1'b0;
    io_master_rlast  = 1'b0;
    @(negedge clock);
    check("resp_valid", 64'(ch_resp_valid), 64'(oh));
    check("resp_data", ch_resp_data, data);
    check("resp_last", 64'(ch_resp_last), 64'd1);
    check("resp_err", 64'(ch_resp_err), 64'(exp_err));
    check("state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("rr_ptr", 64'(dbg_rr_ptr), 64'(exp_ptr));
    check("no_overlap_ready", 64'(ch_req_ready), 64'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    ch_req_valid = '0; ch_req_write = '0; ch_req_addr = '0;
    ch_req_size = {3'd3, 3'd3, 3'd3}; ch_req_wdata = '0; ch_req_wstrb = '0;
    io_master_arready = 1'b0; io_master_rvalid = 1'b0; io_master_rdata = '0;
    io_master_rresp = 2'b00; io_master_rlast = 1'b0; io_master_rid = '0;
    io_master_awready = 1'b0; io_master_wready = 1'b0;
    io_master_bvalid = 1'b0; io_master_bresp = 2'b00; io_master_bid = '0;

    // Reset with requests pending: nothing may be granted or driven.
    ch_req_valid = 3'b111;
    cyc();
    cyc();
    @(negedge clock);
    check("rst_ready", 64'(ch_req_ready), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_ptr", 64'(dbg_rr_ptr), 64'd0);
    check("rst_valids", 64'({io_master_arvalid, io_master_rready, io_master_awvalid,
                             io_master_wvalid, io_master_bready}), 64'd0);
    check("rst_resp", 64'({ch_resp_valid, ch_resp_last, ch_resp_err}), 64'd0);
    ch_req_valid = '0;
    cyc();

    // Single read on ch0.
    reset = 1'b1;
    ch_req_valid = 3'b001;
    ch_req_addr[0 +: 32] = 32'h8000_0000;
    read_txn(0, 32'h8000_0000, 64'hDEAD_BEEF_0000_0001, 4'd0, 1'b0, 2'd1);
    ch_req_valid = '0;

    // Contention: all three channels keep requesting.
    do_reset();
    ch_req_addr = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    ch_req_valid = 3'b111;
    read_txn(0, 32'h0000_0100, 64'h1111_0000_0000_0000, 4'd0, 1'b0, 2'd1);
    cyc();
    read_txn(1, 32'h0000_0200, 64'h1111_0000_0000_0001, 4'd1, 1'b0, 2'd2);
    cyc();
    read_txn(2, 32'h0000_0300, 64'h1111_0000_0000_0002, 4'd2, 1'b0, 2'd0);
    cyc();
    read_txn(0, 32'h0000_0100, 64'h1111_0000_0000_0003, 4'd0, 1'b0, 2'd1);
    ch_req_valid = '0;

    // Write on ch1: AW accepted in cycle 1, W in cycle 3, SLVERR response.
    cyc();
    ch_req_valid = 3'b010;
    ch_req_write = 3'b010;
    ch_req_addr[32 +: 32] = 32'h0000_1000;
    ch_req_wdata[64 +: 64] = 64'h0123_4567_89AB_CDEF;
    ch_req_wstrb[8 +: 8] = 8'h0F;
    @(negedge clock);
    check("w_grant_ready", 64'(ch_req_ready), 64'b010);
    cyc();
    ch_req_valid = '0;
    ch_req_write = '0;
    @(negedge clock);
    check("w1_state", 64'(dbg_state), 64'(ST_WREQ));
    check("w1_aw_w_valid", 64'({io_master_awvalid, io_master_wvalid, io_master_wlast}), 64'b111);
    check("w1_awaddr", 64'(io_master_awaddr), 64'h1000);
    check("w1_awid_len", 64'({io_master_awid, io_master_awlen, io_master_awburst}),
          64'({4'd1, 8'd0, 2'b01}));
    check("w1_wdata", io_master_wdata, 64'h0123_4567_89AB_CDEF);
    check("w1_wstrb", 64'(io_master_wstrb), 64'h0F);
    io_master_awready = 1'b1;
    cyc();
    io_master_awready = 1'b0;
    @(negedge clock);
    check("w2_valids", 64'({io_master_awvalid, io_master_wvalid}), 64'b01);
    check("w2_state", 64'(dbg_state), 64'(ST_WREQ));
    cyc();
    io_master_wready = 1'b1;
    cyc();
    io_master_wready = 1'b0;
    @(negedge clock);
    check("w4_state", 64'(dbg_state), 64'(ST_WRESP));
    check("w4_bready_wvalid", 64'({io_master_bready, io_master_wvalid}), 64'b10);
    cyc();
    io_master_bvalid = 1'b1;
    io_master_bresp  = 2'b10;
    io_master_bid    = 4'd1;
    @(negedge clock);
    check("w5_no_resp_yet", 64'(ch_resp_valid), 64'd0);
    cyc();
    io_master_bvalid = 1'b0;
    io_master_bresp  = 2'b00;
    @(negedge clock);
    check("w6_resp", 64'({ch_resp_valid, ch_resp_last, ch_resp_err}), 64'b010_1_1);
    check("w6_state", 64'(dbg_state), 64'(ST_IDLE));
    check("w6_ptr", 64'(dbg_rr_ptr), 64'd2);
    check("w6_bready", 64'(io_master_bready), 64'd0);

    // ID mismatch on a ch0 read.
    cyc();
    ch_req_valid = 3'b001;
    ch_req_addr[0 +: 32] = 32'h8000_0040;
    read_txn(0, 32'h8000_0040, 64'h0000_0000_5555_AAAA, 4'd3, 1'b1, 2'd1);
    ch_req_valid = '0;

    // Reset while waiting in RDATA, then a clean read on ch1.
    cyc();
    ch_req_valid = 3'b010;
    ch_req_addr[32 +: 32] = 32'h0000_2000;
    @(negedge clock);
    check("mid_grant_ready", 64'(ch_req_ready), 64'b010);
    cyc();
    ch_req_valid = '0;
    io_master_arready = 1'b1;
    cyc();
    io_master_arready = 1'b0;
    @(negedge clock);
    check("mid_state_rdata", 64'(dbg_state), 64'(ST_RDATA));
    check("mid_ptr_before", 64'(dbg_rr_ptr), 64'd1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clock);
    check("mid_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("mid_ptr_zero", 64'(dbg_rr_ptr), 64'd0);
    check("mid_valids", 64'({io_master_arvalid, io_master_rready, ch_resp_valid}), 64'd0);
    cyc();
    ch_req_valid = 3'b010;
    read_txn(1, 32'h0000_2000, 64'hCAFE_F00D_0000_0002, 4'd1, 1'b0, 2'd2);
    ch_req_valid = '0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
